// File: rtl/serial_word_compare_if.sv
// serial_word_compare_if
//   Bundles the serial compare handshake between the upstream bit comparator
//   (and its controller) and the word-level compare block.
//   Signals:
//     start    : begin a new word comparison
//     valid    : f3 carries a valid bit this cycle
//     f3       : per-bit equality from the comparator (1 = bits equal)
//     busy     : comparison in progress
//     done     : one-cycle pulse, result outputs just updated
//     eq       : 1 = every bit of the last word matched
//     mismatch : number of unequal bits in the last word (0..WIDTH)
//   Modports:
//     master : drives start/valid/f3, observes the results
//     slave  : the compare block itself
interface serial_word_compare_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic          start;
  logic          valid;
  logic          f3;
  logic          busy;
  logic          done;
  logic          eq;
  logic [CW-1:0] mismatch;

  modport master (
    output start, valid, f3,
    input  busy, done, eq, mismatch
  );

  modport slave (
    input  start, valid, f3,
    output busy, done, eq, mismatch
  );
endinterface

// File: rtl/serial_word_compare.sv
// serial_word_compare
//   Accumulates WIDTH valid per-bit equality flags (f3) into a whole-word
//   result: eq (all bits matched), mismatch (count of unequal bits) and a
//   one-cycle done pulse. VALID=0 cycles inside a word are stalls.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : serial_word_compare_if.slave (start/valid/f3 in,
//             busy/done/eq/mismatch out)
module serial_word_compare #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_word_compare_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [CW-1:0] bit_cnt_reg;
  logic [CW-1:0] mm_cnt_reg;
  logic          eq_run_reg;
  logic          eq_reg;
  logic [CW-1:0] mismatch_reg;

  logic          start_word;
  logic          bit_take;
  logic          last_bit;
  logic [CW-1:0] mm_inc;
  logic [CW-1:0] mm_cnt_next;

  // A new word may begin from IDLE or directly out of FIN (back-to-back).
  assign start_word  = bus.start && (state_reg == IDLE || state_reg == FIN);
  assign bit_take    = (state_reg == CMP) && bus.valid;
  assign last_bit    = bit_take && (bit_cnt_reg == CW'(WIDTH - 1));
  assign mm_inc      = {{(CW-1){1'b0}}, ~bus.f3};
  // Includes the bit sampled this cycle so the final bit lands in the result.
  assign mm_cnt_next = mm_cnt_reg + mm_inc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (bus.start) state_next = CMP;
      CMP:     if (last_bit)  state_next = FIN;
      FIN:     state_next = bus.start ? CMP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded straight from the state register, so they are glitch-free
  always_comb begin
    bus.busy = (state_reg == CMP);
    bus.done = (state_reg == FIN);
  end

  // Running counters and the held result. The result is only written on the
  // edge that enters FIN, so it stays stable for the whole of the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg  <= '0;
      mm_cnt_reg   <= '0;
      eq_run_reg   <= 1'b0;
      eq_reg       <= 1'b0;
      mismatch_reg <= '0;
    end else if (start_word) begin
      bit_cnt_reg <= '0;
      mm_cnt_reg  <= '0;
      eq_run_reg  <= 1'b1;
    end else if (bit_take) begin
      bit_cnt_reg <= bit_cnt_reg + 1'b1;
      mm_cnt_reg  <= mm_cnt_next;
      if (!bus.f3) begin
        eq_run_reg <= 1'b0;
      end
      if (last_bit) begin
        eq_reg       <= eq_run_reg & bus.f3;
        mismatch_reg <= mm_cnt_next;
      end
    end
  end

  assign bus.eq       = eq_reg;
  assign bus.mismatch = mismatch_reg;
endmodule

// File: tb/tb_serial_word_compare.sv
// tb_serial_word_compare
//   Self-checking bench for serial_word_compare: directed words (all-equal,
//   mixed, stalled, all-unequal, restart handling, mid-word reset) followed by
//   randomized words, each checked against a word-level reference model.
module tb_serial_word_compare;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic prev_eq;
  int   prev_mm;

  serial_word_compare_if #(.WIDTH(WIDTH)) bus ();

  serial_word_compare #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_held(input string tag);
    check({tag, ":eq_held"}, 32'(bus.eq), 32'(prev_eq));
    check({tag, ":mm_held"}, 32'(bus.mismatch), 32'(prev_mm));
  endtask

  // Feed one word. bits[i] is the i-th serial bit. gap_before[i] inserts one
  // stall cycle (F3=0) before bit i; rand_stall adds random stalls with random
  // F3; poke_start drives random START during the word; restart_after leaves
  // the bench at the FIN cycle so the next call restarts back-to-back.
  task automatic run_word(input logic [WIDTH-1:0] bits, input logic [WIDTH-1:0] gap_before,
                          input bit rand_stall, input bit poke_start,
                          input bit restart_after, input string name);
    int   zeros;
    int   nst;
    logic exp_eq;
    zeros = 0;
    for (int i = 0; i < WIDTH; i++) if (bits[i] == 1'b0) zeros++;
    exp_eq = (bits == {WIDTH{1'b1}});

    bus.start = 1'b1;
    bus.valid = 1'($urandom);
    bus.f3    = 1'($urandom);
    @(negedge clk);
    check({name, ":busy_on"}, 32'(bus.busy), 32'd1);
    check({name, ":done_off"}, 32'(bus.done), 32'd0);

    for (int i = 0; i < WIDTH; i++) begin
      nst = int'(gap_before[i]) + (rand_stall ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < nst; s++) begin
        bus.start = poke_start ? 1'($urandom) : 1'b0;
        bus.valid = 1'b0;
        bus.f3    = rand_stall ? 1'($urandom) : 1'b0;
        @(negedge clk);
        check({name, ":stall_busy"}, 32'(bus.busy), 32'd1);
        check({name, ":stall_done"}, 32'(bus.done), 32'd0);
        check_held({name, ":stall"});
      end
      bus.start = poke_start ? 1'($urandom) : 1'b0;
      bus.valid = 1'b1;
      bus.f3    = bits[i];
      @(negedge clk);
      if (i < WIDTH - 1) begin
        check({name, ":cmp_busy"}, 32'(bus.busy), 32'd1);
        check({name, ":cmp_done"}, 32'(bus.done), 32'd0);
        check_held({name, ":cmp"});
      end
    end

    check({name, ":done"}, 32'(bus.done), 32'd1);
    check({name, ":fin_busy"}, 32'(bus.busy), 32'd0);
    check({name, ":eq"}, 32'(bus.eq), 32'(exp_eq));
    check({name, ":mismatch"}, 32'(bus.mismatch), 32'(zeros));
    $display("word %s bits=%b eq=%0d mismatch=%0d (model eq=%0d mismatch=%0d)",
             name, bits, bus.eq, bus.mismatch, exp_eq, zeros);
    prev_eq = exp_eq;
    prev_mm = zeros;

    if (!restart_after) begin
      bus.start = 1'b0;
      bus.valid = 1'($urandom);
      bus.f3    = 1'($urandom);
      @(negedge clk);
      check({name, ":idle_done"}, 32'(bus.done), 32'd0);
      check({name, ":idle_busy"}, 32'(bus.busy), 32'd0);
      check_held({name, ":idle"});
    end
  endtask

  // Start a word, feed three bits, then reset asynchronously mid-comparison.
  task automatic reset_mid_word(input string name);
    bus.start = 1'b1;
    bus.valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b0;
      bus.valid = 1'b1;
      bus.f3    = 1'b1;
      @(negedge clk);
    end
    check({name, ":pre_busy"}, 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check({name, ":rst_busy"}, 32'(bus.busy), 32'd0);
    check({name, ":rst_done"}, 32'(bus.done), 32'd0);
    check({name, ":rst_eq"}, 32'(bus.eq), 32'd0);
    check({name, ":rst_mm"}, 32'(bus.mismatch), 32'd0);
    $display("reset %s applied mid-word: busy=%0d done=%0d eq=%0d mismatch=%0d",
             name, bus.busy, bus.done, bus.eq, bus.mismatch);
    bus.valid = 1'b1;
    bus.f3    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    prev_eq = 1'b0;
    prev_mm = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check({name, ":post_done"}, 32'(bus.done), 32'd0);
      check({name, ":post_busy"}, 32'(bus.busy), 32'd0);
      check_held({name, ":post"});
    end
    bus.valid = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    vectors     = 0;
    miscompares = 0;
    prev_eq     = 1'b0;
    prev_mm     = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.valid   = 1'b0;
    bus.f3      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset:busy", 32'(bus.busy), 32'd0);
    check("reset:done", 32'(bus.done), 32'd0);
    check("reset:eq", 32'(bus.eq), 32'd0);
    check("reset:mm", 32'(bus.mismatch), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // all-equal word, then a mid-word reset that must clear eq=1
    run_word(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, "t2_all_equal");
    reset_mid_word("t1a");
    // F3 serial pattern 1,0,1,1,0,0,1,1 -> three mismatches
    run_word(8'b1100_1101, 8'h00, 1'b0, 1'b0, 1'b0, "t3_mixed");
    // stalls after bits 2 and 5 with F3=0 during the gaps
    run_word(8'hFF, 8'b0010_0100, 1'b0, 1'b0, 1'b0, "t4_stalls");
    // all-unequal: maximum count, then a reset that must clear mismatch=8
    run_word(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "t6_all_unequal");
    reset_mid_word("t1b");
    // START pokes during CMP are ignored; START held in FIN restarts at once
    run_word(8'b1011_0110, 8'h00, 1'b0, 1'b1, 1'b1, "t5_restart_a");
    run_word(8'h0F, 8'h00, 1'b0, 1'b1, 1'b1, "t5_restart_b");
    run_word(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, "t5_restart_c");

    for (int n = 0; n < 30; n++) begin
      w = WIDTH'($urandom);
      if (n % 10 == 3) w = '1;
      if (n % 10 == 7) w = '0;
      run_word(w, WIDTH'($urandom), 1'b1, 1'($urandom), 1'($urandom), $sformatf("rand%0d", n));
    end
    bus.start = 1'b0;
    bus.valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
